// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared helpers for the parametrised select/arbitration mux.
package mux_arb_pkg;
  function automatic int wrap_inc(int i, int n);
    return (i == n - 1) ? 0 : i + 1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant, scanning from ptr and wrapping modulo NCH.
module rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int NCH = 4,
  localparam int SELW = $clog2(NCH)
) (
  input  logic [NCH-1:0]  valid,
  input  logic [SELW-1:0] ptr,
  output logic [NCH-1:0]  grant
);
  always_comb begin
    logic [SELW-1:0] j;
    logic found;
    grant = '0;
    found = 1'b0;
    j = ptr;
    for (int k = 0; k < NCH; k++) begin
      if (!found && valid[j]) begin
        grant[j] = 1'b1;
        found = 1'b1;
      end
      j = SELW'(wrap_inc(int'(j), NCH));
    end
  end
endmodule

// File: rtl/mux_arb_n.sv
// mux_arb_n: NCH-way valid/ready mux with static-select or round-robin mode and one output register.
module mux_arb_n
  import mux_arb_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int NCH = 4,
  localparam int SELW = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mode_rr,
  input  logic [SELW-1:0]      sel,
  input  logic [NCH-1:0]       in_valid,
  input  logic [NCH*WIDTH-1:0] in_data,
  output logic [NCH-1:0]       in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_ch,
  input  logic                 out_ready
);
  logic [SELW-1:0]  ptr, g_ch;
  logic [NCH-1:0]   rr_grant, grant;
  logic [WIDTH-1:0] g_data;
  logic             load, xfer;
  rr_arbiter #(.NCH(NCH)) u_rr (.valid(in_valid), .ptr(ptr), .grant(rr_grant));
  // AND-OR select keeps non-power-of-2 NCH cheap; sel beyond NCH-1 simply matches nothing
  always_comb begin
    grant = '0;
    g_data = '0;
    g_ch = '0;
    for (int i = 0; i < NCH; i++) begin
      grant[i] = mode_rr ? rr_grant[i] : (sel == SELW'(i)) && in_valid[i];
      g_data |= in_data[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}};
      g_ch |= grant[i] ? SELW'(i) : '0;
    end
  end
  assign load = !out_valid || out_ready;
  assign in_ready = (load && !reset) ? grant : '0;
  assign xfer = |in_ready;
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_ch <= '0;
      ptr <= '0;
    end else if (load) begin
      out_valid <= xfer;
      if (xfer) begin
        out_data <= g_data;
        out_ch <= g_ch;
      end
      if (xfer && mode_rr) ptr <= SELW'(wrap_inc(int'(g_ch), NCH));
    end
  end
endmodule

// File: doc/mux_arb_n.md
Name: mux_arb_n

Overview:
- Parametrised successor to the fixed 4-way 12-bit select mux.
- Selects one of NCH WIDTH-bit input channels and forwards it through a single registered output stage.
- Every input and the output use valid/ready handshakes.
- Two runtime modes:
  - static select: the legacy mux behaviour, channel chosen by sel.
  - round-robin arbitration: for shared-bus merging in the datapath.

Parameters:
- WIDTH, 12, data width per channel.
- NCH, 4, number of input channels, 2..16.
- SELW, $clog2(NCH), width of sel and out_ch (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- mode_rr  in  1  1 = round-robin arbitration, 0 = static select by sel.
- sel  in  SELW  channel index used when mode_rr=0.
- in_valid  in  NCH  per-channel valid.
- in_data  in  NCH x WIDTH  per-channel data, packed; channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  out  NCH  per-channel ready; at most one bit high in any cycle.
- out_valid  out  1  output register holds a word.
- out_data  out  WIDTH  registered data.
- out_ch  out  SELW  index of the channel the held word came from.
- out_ready  in  1  downstream accepts when high together with out_valid.

Behaviour:
- Reset (synchronous, active-high; takes priority over all events):
  - Clears out_valid, out_data, out_ch, and the round-robin pointer ptr to 0.
  - Any word held mid-transfer is discarded.
  - in_ready is all-zero during the reset cycle.
- load = !out_valid || out_ready; the output stage is free this cycle.
- Grant (combinational, one-hot or zero):
  - mode_rr=0: grant[sel] = in_valid[sel]. If sel >= NCH, no grant.
  - mode_rr=1: first i with in_valid[i]=1, scanning ptr, ptr+1, … NCH-1, 0, … ptr-1 (wraps modulo NCH).
- in_ready[i] = grant[i] && load. A transfer on channel i occurs when in_valid[i] && in_ready[i].
- On a transfer:
  - out_data <= in_data[i]; out_ch <= i; out_valid <= 1.
  - Latency is exactly 1 cycle from input acceptance to out_valid.
- On load with no grant: out_valid <= 0. out_data and out_ch hold their previous values.
- Stall: while out_valid && !out_ready, out_data and out_ch stay stable and all in_ready are 0.
- Simultaneous out_ready and new input: the output pops and reloads in the same cycle. Full throughput is one word per clock.
- Pointer:
  - Updates only on a transfer in mode_rr=1: ptr <= (i == NCH-1) ? 0 : i+1.
  - In mode_rr=0 the pointer holds.
  - Requesters are never starved: each channel waits at most NCH-1 grants.
- mode_rr or sel changes take effect at the next grant evaluation. A word already held is unaffected.
- The block never drops or duplicates a word absent reset.
- Input valid/data must stay stable while valid is high and unaccepted; this is a protocol rule of the block.

Decomposition:
- Shared package mux_arb_pkg: a function for the modulo-NCH increment of ptr, and any constants used by more than one file.
- One sub-module: rr_arbiter, a combinational grant from in_valid and ptr, parametrised by NCH.
- The top-level file holds mode selection, the output register and the pointer update.
- The data select is an AND-OR of grant and in_data, not a mux2 tree, so NCH need not be a power of 2.

Test Plan:
- Reset: assert reset 2 cycles with all in_valid=1 → out_valid=0, out_data=0, out_ch=0, in_ready=0000. On release, first grant goes to ch0.
- Static mode, NCH=4, WIDTH=12:
  - Stimulus: mode_rr=0, sel=2, in_data = {0x333, 0x222, 0x111, 0x000}, all valid, out_ready=1.
  - Response: only in_ready[2]=1; out_data=0x222, out_ch=2 every cycle from cycle 1.
  - Then sel=3 → next word 0x333.
- Round-robin fairness:
  - Stimulus: mode_rr=1, all 4 valid, out_ready=1.
  - Response: out_ch sequence 0,1,2,3,0,1 on consecutive cycles.
  - With only ch1 and ch3 valid → sequence 1,3,1,3.
- Backpressure: out_ready=0 for 3 cycles while out_valid=1 holding 0x111 → out_data stays 0x111 and in_ready=0000. When out_ready returns to 1, the next word appears the following cycle and nothing is lost.
- Boundaries:
  - Pointer wrap: last grant on ch3 → next scan starts at ch0.
  - sel=5 with NCH=6 is accepted; sel=7 with NCH=6 gives no grant and out_valid drops to 0.
  - Mid-stream reset discards the held word and restarts ptr at 0.
- Scoreboard:
  - Random valid/ready traffic, 10k cycles, NCH=5, WIDTH=8.
  - Per-channel order is preserved and no word is lost or duplicated.
  - No channel waits more than 4 grants while valid.
